red_pitaya_asg_trig_cond: RTL

Trigger conditioning stage directly upstream of the double-buffered arbitrary signal generator; its outputs drive the generator's trig_a_i / trig_b_i.
- Synchronises and debounces the asynchronous external trigger pin, then detects its edges.
- Applies a per-channel source select and a per-channel holdoff window.
- Produces clean single-cycle trigger pulses for channel A and channel B.

---
 rtl/red_pitaya_asg_pkg.sv | 16 +
 rtl/red_pitaya_trig_holdoff.sv | 80 ++++++++
 rtl/red_pitaya_asg_trig_cond.sv | 98 +++++++++
 3 files changed

// File: rtl/red_pitaya_asg_pkg.sv
// Shared types for the ASG trigger conditioning stage.
package red_pitaya_asg_pkg;

  typedef enum logic [2:0] {
    TRIG_NONE  = 3'd0,
    TRIG_SW    = 3'd1,
    TRIG_EXT_R = 3'd2,
    TRIG_EXT_F = 3'd3
  } trig_src_t;

  typedef enum logic {
    HO_IDLE = 1'b0,
    HO_HOLD = 1'b1
  } ho_state_t;

endpackage

// File: rtl/red_pitaya_trig_holdoff.sv
// One trigger channel: source decode, holdoff FSM, drop counter, output pulse.
module red_pitaya_trig_holdoff
  import red_pitaya_asg_pkg::*;
#(
  parameter int HOW = 32,
  parameter int DRW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sw_trig,
  input  logic           ext_rise,
  input  logic           ext_fall,
  input  logic [2:0]     src,
  input  logic [HOW-1:0] holdoff,
  output logic           trig,
  output logic           busy,
  output logic [DRW-1:0] drop
);

  localparam logic [HOW-1:0] HCNT_ZERO = {HOW{1'b0}};
  localparam logic [HOW-1:0] HCNT_ONE  = {{(HOW-1){1'b0}}, 1'b1};
  localparam logic [DRW-1:0] DROP_ZERO = {DRW{1'b0}};
  localparam logic [DRW-1:0] DROP_MAX  = {DRW{1'b1}};
  localparam logic [DRW-1:0] DROP_ONE  = {{(DRW-1){1'b0}}, 1'b1};

  ho_state_t      state;
  logic [HOW-1:0] hcnt;
  logic           evt;

  // Reserved selector codes fall into the default and never fire.
  always_comb begin
    evt = 1'b0;
    case (src)
      TRIG_SW:    evt = sw_trig;
      TRIG_EXT_R: evt = ext_rise;
      TRIG_EXT_F: evt = ext_fall;
      default:    evt = 1'b0;
    endcase
  end

  // Holdoff length is captured at acceptance so later register writes cannot stretch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HO_IDLE;
      hcnt  <= HCNT_ZERO;
      trig  <= 1'b0;
      busy  <= 1'b0;
      drop  <= DROP_ZERO;
    end else begin
      trig <= 1'b0;
      case (state)
        HO_IDLE: begin
          if (evt) begin
            trig <= 1'b1;
            hcnt <= holdoff;
            if (holdoff != HCNT_ZERO) begin
              state <= HO_HOLD;
              busy  <= 1'b1;
            end
          end
        end
        HO_HOLD: begin
          hcnt <= hcnt - HCNT_ONE;
          if (hcnt == HCNT_ONE) begin
            state <= HO_IDLE;
            busy  <= 1'b0;
          end
          if (evt && (drop != DROP_MAX)) begin
            drop <= drop + DROP_ONE;
          end
        end
        default: begin
          state <= HO_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/red_pitaya_asg_trig_cond.sv
// Trigger conditioning ahead of the ASG: sync + debounce of the external pin,
// edge detection, and two independent holdoff channels.
module red_pitaya_asg_trig_cond
  import red_pitaya_asg_pkg::*;
#(
  parameter int DBW = 20,
  parameter int HOW = 32,
  parameter int DRW = 16
) (
  input  logic           dac_clk_i,
  input  logic           dac_rst_i,
  input  logic           ext_trig_i,
  input  logic           sw_trig_a_i,
  input  logic           sw_trig_b_i,
  input  logic [2:0]     src_a_i,
  input  logic [2:0]     src_b_i,
  input  logic [DBW-1:0] deb_len_i,
  input  logic [HOW-1:0] holdoff_a_i,
  input  logic [HOW-1:0] holdoff_b_i,
  output logic           trig_a_o,
  output logic           trig_b_o,
  output logic           busy_a_o,
  output logic           busy_b_o,
  output logic           ext_lvl_o,
  output logic [31:0]    ext_cnt_o,
  output logic [DRW-1:0] drop_a_o,
  output logic [DRW-1:0] drop_b_o
);

  localparam logic [DBW-1:0] DCNT_ZERO = {DBW{1'b0}};
  localparam logic [DBW-1:0] DCNT_ONE  = {{(DBW-1){1'b0}}, 1'b1};

  logic           s1;
  logic           s2;
  logic           lvl;
  logic           lvl_q;
  logic [DBW-1:0] dcnt;
  logic           rise;
  logic           fall;

  assign rise      = lvl & ~lvl_q;
  assign fall      = ~lvl & lvl_q;
  assign ext_lvl_o = lvl;

  // A new level is adopted only after D+1 consecutive agreeing samples on s2.
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      lvl       <= 1'b0;
      lvl_q     <= 1'b0;
      dcnt      <= DCNT_ZERO;
      ext_cnt_o <= 32'd0;
    end else begin
      s1    <= ext_trig_i;
      s2    <= s1;
      lvl_q <= lvl;
      if (s2 == lvl) begin
        dcnt <= DCNT_ZERO;
      end else if (dcnt >= deb_len_i) begin
        lvl  <= s2;
        dcnt <= DCNT_ZERO;
      end else begin
        dcnt <= dcnt + DCNT_ONE;
      end
      if (rise) begin
        ext_cnt_o <= ext_cnt_o + 32'd1;
      end
    end
  end

  red_pitaya_trig_holdoff #(.HOW(HOW), .DRW(DRW)) u_ch_a (
    .clk      (dac_clk_i),
    .rst      (dac_rst_i),
    .sw_trig  (sw_trig_a_i),
    .ext_rise (rise),
    .ext_fall (fall),
    .src      (src_a_i),
    .holdoff  (holdoff_a_i),
    .trig     (trig_a_o),
    .busy     (busy_a_o),
    .drop     (drop_a_o)
  );

  red_pitaya_trig_holdoff #(.HOW(HOW), .DRW(DRW)) u_ch_b (
    .clk      (dac_clk_i),
    .rst      (dac_rst_i),
    .sw_trig  (sw_trig_b_i),
    .ext_rise (rise),
    .ext_fall (fall),
    .src      (src_b_i),
    .holdoff  (holdoff_b_i),
    .trig     (trig_b_o),
    .busy     (busy_b_o),
    .drop     (drop_b_o)
  );

endmodule
